sar_scan_ctrl: RTL
==================

Name: sar_scan_ctrl

Overview:
- Next-generation SAR ADC controller with a width-parametrised bit-search engine.
- Adds multi-channel scanning through an analog mux, per-sample settle time and power-of-two oversampling/averaging.
- Supports single-scan and continuous modes and a valid/ready result handshake.
- Sits between the analog front end (mux, S/H, DAC, clocked comparator) and the digital sample consumer.

Parameters:
- SIZE, 8, DAC/result width in bits (>=2)
- NCH, 4, number of analog channels (>=1); CHW = max(1, clog2(NCH))
- SETTLE, 2, sample/settle cycles before each conversion (>=1)
- AVG_LOG2, 0, log2 of samples averaged per channel result (0..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a scan; sampled only in IDLE
- cont  in  1  continuous mode: wrap and rescan; sampled at each scan end
- ch_mask  in  NCH  enabled channels; latched when start is accepted
- cmp  in  1  comparator: 1 = input >= DAC trial, keep bit
- dac  out  SIZE  DAC trial code
- dacn  out  SIZE  ~dac for active-low DAC
- clkn  out  1  ~clk for the clocked comparator
- ch_sel  out  CHW  analog mux select
- sample  out  1  S/H track enable, high during SETTLE
- busy  out  1  high in every state except IDLE
- data  out  SIZE  averaged result
- data_ch  out  CHW  channel of data
- data_valid  out  1  result available
- data_ready  in  1  consumer accepts result

Behaviour:
- Reset (rst high at posedge): state IDLE; dac=0, ch_sel=0, sample=0, busy=0, data=0, data_ch=0, data_valid=0, accumulator=0.
- Reset mid-operation aborts immediately; no partial result is emitted.
- States and transitions:
  - IDLE: start=1 and ch_mask!=0 -> latch mask, ch_sel = lowest set bit, go to SETTLE. start with mask=0 is ignored. start while busy is ignored.
  - SETTLE: sample=1 for exactly SETTLE cycles, dac=0; then go to CONV.
  - CONV: exactly SIZE cycles, k=0..SIZE-1. In cycle k, dac = kept bits | (1<<(SIZE-1-k)). At the posedge ending cycle k, the trial bit is kept if cmp=1, cleared if cmp=0. On the final edge, the code is added into an accumulator of SIZE+AVG_LOG2 bits (cannot overflow).
    - If fewer than 2^AVG_LOG2 samples have been taken -> SETTLE, same channel.
    - Otherwise -> OUT.
  - OUT: data = accumulator >> AVG_LOG2 (truncate), data_ch = channel, data_valid=1. data and data_ch are stable while data_valid=1 and data_ready=0. Transfer occurs on a cycle with data_valid & data_ready; no conversion progresses while stalled. After transfer, data_valid=0 next cycle, accumulator cleared, then:
    - next higher set mask bit exists -> SETTLE on that channel
    - else cont=1 -> SETTLE on lowest set bit (wrap)
    - else -> IDLE
- Latency: data_valid rises exactly 1 + 2^AVG_LOG2*(SETTLE+SIZE) cycles after the start edge.
- With data_ready held high, OUT lasts exactly 1 cycle per channel.
- ch_mask changes after start have no effect until the next accepted start.
- Clearing cont mid-scan finishes the current scan, then returns to IDLE.
- Extremes: cmp always 1 -> data = 2^SIZE-1; cmp always 0 -> data = 0.
- NCH=1: ch_sel and data_ch are constant 0.

Decomposition:
- Shared package sar_pkg:
  - state enum (IDLE, SETTLE, CONV, OUT)
  - clog2-based width function for CHW and the count widths
- Sub-module sar_core: single-conversion bit-search engine.
  - Ports: clk, rst, go, cmp, dac, result, done.
  - Owns the one-hot shift pointer and result register.
- sar_scan_ctrl owns settle/sample counters, channel selection, accumulator and handshake.

Test Plan:
- SIZE=8, NCH=4, SETTLE=2, AVG_LOG2=0, mask=0001, comparator model input 0xA5 -> data=0xA5, data_ch=0; data_valid at cycle 11 after start; dac trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
- mask=1010, inputs ch1=0x3C and ch3=0xF0, cont=0 -> two results in order (ch1,0x3C) then (ch3,0xF0), then busy=0.
- AVG_LOG2=2, successive samples 0x40,0x41,0x42,0x44 -> data=0x41 (sum 0x107 >> 2); exactly one data_valid pulse.
- data_ready low 5 cycles during OUT -> data/data_ch/data_valid held constant, ch_sel and dac unchanged, no SETTLE entry until ready.
- cont=1, mask=0101 -> channels 0,2,0,2...; clear cont during ch0 conversion -> ch2 result emitted, then IDLE; start with mask=0000 -> stays IDLE.
- rst asserted mid-CONV -> next cycle all outputs at reset values; cmp stuck 1 / stuck 0 -> data 0xFF / 0x00.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and width helpers for the SAR scan controller and its bit-search core.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONV,
    ST_OUT
  } state_t;

  // Width of a counter or index covering n values, never narrower than one bit.
  function automatic int cntw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_core.sv
// Single-conversion successive-approximation engine: one trial bit per cycle, MSB first.
module sar_core #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            cmp,
  output logic [SIZE-1:0] dac,
  output logic [SIZE-1:0] result,
  output logic            done
);

  logic [SIZE-1:0] ptr_reg;
  logic [SIZE-1:0] code_reg;
  logic [SIZE-1:0] kept;

  // Resolve the current trial bit against the comparator.
  assign kept   = cmp ? code_reg : (code_reg & ~ptr_reg);
  assign dac    = code_reg;
  assign result = kept;
  assign done   = ptr_reg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg  <= '0;
      code_reg <= '0;
    end else if (go) begin
      ptr_reg  <= {1'b1, {(SIZE-1){1'b0}}};
      code_reg <= {1'b1, {(SIZE-1){1'b0}}};
    end else if (|ptr_reg) begin
      ptr_reg  <= ptr_reg >> 1;
      // After the LSB decision the DAC returns to zero for the next settle window.
      code_reg <= ptr_reg[0] ? '0 : (kept | (ptr_reg >> 1));
    end
  end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Multi-channel SAR scan controller: channel sequencing, settle timing, averaging and result handshake.
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter  int SIZE     = 8,
  parameter  int NCH      = 4,
  parameter  int SETTLE   = 2,
  parameter  int AVG_LOG2 = 0,
  localparam int CHW      = cntw(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cont,
  input  logic [NCH-1:0]  ch_mask,
  input  logic            cmp,
  output logic [SIZE-1:0] dac,
  output logic [SIZE-1:0] dacn,
  output logic            clkn,
  output logic [CHW-1:0]  ch_sel,
  output logic            sample,
  output logic            busy,
  output logic [SIZE-1:0] data,
  output logic [CHW-1:0]  data_ch,
  output logic            data_valid,
  input  logic            data_ready
);

  localparam int SW   = cntw(SETTLE);
  localparam int AW   = SIZE + AVG_LOG2;
  localparam int CW   = AVG_LOG2 + 1;
  localparam int NAVG = 1 << AVG_LOG2;

  state_t          state_reg;
  logic [NCH-1:0]  mask_reg;
  logic [NCH-1:0]  above;
  logic [CHW-1:0]  ch_reg;
  logic [SW-1:0]   settle_cnt_reg;
  logic [CW-1:0]   samp_cnt_reg;
  logic [AW-1:0]   acc_reg;
  logic [AW-1:0]   acc_sum;
  logic [SIZE-1:0] data_reg;
  logic [CHW-1:0]  data_ch_reg;
  logic [SIZE-1:0] core_result;
  logic            core_done;
  logic            sample_reg;
  logic            busy_reg;
  logic            dv_reg;
  logic            go;
  logic            settle_last;
  logic            last_sample;

  function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CHW'(i);
    end
  endfunction

  // Enabled channels strictly above the current one, for in-order scanning.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_above
      localparam logic [CHW-1:0] GI = CHW'(gi);
      assign above[gi] = mask_reg[gi] && (GI > ch_reg);
    end
  endgenerate

  assign settle_last = (settle_cnt_reg == SW'(SETTLE - 1));
  assign go          = (state_reg == ST_SETTLE) && settle_last;
  assign last_sample = (samp_cnt_reg == CW'(NAVG - 1));
  assign acc_sum     = acc_reg + AW'(core_result);

  sar_core #(
    .SIZE (SIZE)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .cmp    (cmp),
    .dac    (dac),
    .result (core_result),
    .done   (core_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mask_reg       <= '0;
      ch_reg         <= '0;
      settle_cnt_reg <= '0;
      samp_cnt_reg   <= '0;
      acc_reg        <= '0;
      data_reg       <= '0;
      data_ch_reg    <= '0;
      sample_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      dv_reg         <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && |ch_mask) begin
            mask_reg       <= ch_mask;
            ch_reg         <= lowest_set(ch_mask);
            settle_cnt_reg <= '0;
            samp_cnt_reg   <= '0;
            acc_reg        <= '0;
            sample_reg     <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_last) begin
            sample_reg <= 1'b0;
            state_reg  <= ST_CONV;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        ST_CONV: begin
          if (core_done) begin
            acc_reg <= acc_sum;
            if (last_sample) begin
              data_reg    <= SIZE'(acc_sum >> AVG_LOG2);
              data_ch_reg <= ch_reg;
              dv_reg      <= 1'b1;
              state_reg   <= ST_OUT;
            end else begin
              samp_cnt_reg   <= samp_cnt_reg + 1'b1;
              settle_cnt_reg <= '0;
              sample_reg     <= 1'b1;
              state_reg      <= ST_SETTLE;
            end
          end
        end
        ST_OUT: begin
          // Everything holds until the consumer takes the result.
          if (data_ready) begin
            dv_reg         <= 1'b0;
            acc_reg        <= '0;
            samp_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            if (|above) begin
              ch_reg     <= lowest_set(above);
              sample_reg <= 1'b1;
              state_reg  <= ST_SETTLE;
            end else if (cont) begin
              ch_reg     <= lowest_set(mask_reg);
              sample_reg <= 1'b1;
              state_reg  <= ST_SETTLE;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dacn       = ~dac;
  assign clkn       = ~clk;
  assign ch_sel     = ch_reg;
  assign sample     = sample_reg;
  assign busy       = busy_reg;
  assign data       = data_reg;
  assign data_ch    = data_ch_reg;
  assign data_valid = dv_reg;

endmodule
